// File: rtl/core_pkg.sv
// Shared core definitions: default widths, NOP encoding, fetch FSM states.
package core_pkg;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_INSTR_W   = 32;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INC        = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Next-PC priority mux (branch > jump > stall > pc+4) with alignment check on the winning redirect.
module pc_next_sel
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              redirect_accepted_o,
    output logic              misalign_o
);

    logic [ADDR_W-1:0] target;
    logic              redirect;

    always_comb begin
        target              = branch_en_i ? branch_target_i : jump_target_i;
        redirect            = branch_en_i | jump_en_i;
        misalign_o          = redirect && (target[1:0] != 2'b00);
        redirect_accepted_o = redirect && !misalign_o;
        // A redirect beats stall; a misaligned redirect leaves pc untouched.
        if (misalign_o || (!redirect && stall_i)) begin
            next_pc_o = pc_i;
        end else if (redirect) begin
            next_pc_o = target;
        end else begin
            next_pc_o = pc_i + ADDR_W'(PC_INC);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register, redirect squash and misaligned-target halt.
module fetch_stage
    import core_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DEF_ADDR_W,
    parameter int unsigned        INSTR_W   = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
    parameter int unsigned        CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_plus4,
    output logic               ifid_valid,
    output logic               kill_id,
    output logic               fetch_fault,
    output logic [CNT_W-1:0]   redirect_count
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pcp4_q, pcp4_d;
    logic               valid_q, valid_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0]  next_pc;
    logic               redirect_accepted;
    logic               misalign;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_sel (
        .pc_i                (pc_q),
        .stall_i             (stall),
        .branch_en_i         (branch_en),
        .branch_target_i     (branch_target),
        .jump_en_i           (jump_en),
        .jump_target_i       (jump_target),
        .next_pc_o           (next_pc),
        .redirect_accepted_o (redirect_accepted),
        .misalign_o          (misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // HALT is terminal until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (misalign) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        kill_id = 1'b0;
        case (state_q)
            RUN: begin
                kill_id = branch_en;
                pc_d    = next_pc;
                if (branch_en || jump_en) begin
                    instr_d = NOP_INSTR;
                    pcp4_d  = '0;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = imem_data;
                    pcp4_d  = pc_q + ADDR_W'(PC_INC);
                    valid_d = 1'b1;
                end
                if (misalign) begin
                    fault_d = 1'b1;
                end
                if (redirect_accepted && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HALT: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign imem_addr      = pc_q;
    assign ifid_instr     = instr_q;
    assign ifid_pc_plus4  = pcp4_q;
    assign ifid_valid     = valid_q;
    assign fetch_fault    = fault_q;
    assign redirect_count = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined core. Owns the program counter, drives the instruction-memory address and registers the fetched instruction into the IF/ID pipeline register.
- Consumes `branch_en` and `branch_target` from the branch-enable logic in EX, `jump_en` and `jump_target` from ID, and `stall` from the hazard unit.
- Squashes wrong-path instructions on redirect.
- Traps misaligned redirect targets into a halt state.

Parameters:
- ADDR_W, 32, PC/address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- NOP_INSTR, 0, encoding inserted into IF/ID on squash/reset
- CNT_W, 16, redirect counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID
- branch_en  in  1  branch taken (resolved in EX)
- branch_target  in  ADDR_W  branch destination
- jump_en  in  1  jump decoded in ID
- jump_target  in  ADDR_W  jump destination
- imem_addr  out  ADDR_W  instruction memory address (= pc)
- imem_data  in  INSTR_W  instruction memory read data, combinational, same cycle
- ifid_instr  out  INSTR_W  registered instruction
- ifid_pc_plus4  out  ADDR_W  registered pc+4 of that instruction
- ifid_valid  out  1  IF/ID holds a live instruction
- kill_id  out  1  combinational, squash ID→EX register this cycle
- fetch_fault  out  1  sticky misaligned-target fault
- redirect_count  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset (async, active-high), all registers:
  - pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0
  - fetch_fault=0, redirect_count=0, state=RUN
- Always: imem_addr=pc. Fetch latency is 1 cycle: the instruction at pc appears on ifid_instr at the next edge.
- Next-PC priority in RUN, highest first:
  1. branch_en → branch_target
  2. jump_en → jump_target
  3. stall → pc (hold)
  4. otherwise pc+ADDR_W'(4), wrapping modulo 2^ADDR_W
- A redirect overrides stall: the redirecting instruction is older than the stalled one.
- IF/ID update in RUN:
  - branch_en or jump_en: ifid_instr=NOP_INSTR, ifid_valid=0 (bubble), ifid_pc_plus4=0.
  - else stall: hold all IF/ID fields.
  - else: ifid_instr=imem_data, ifid_pc_plus4=pc+4, ifid_valid=1.
- kill_id = branch_en && state==RUN.
  - Branch: squashes 2 younger instructions (IF/ID via bubble, ID/EX via kill_id).
  - Jump: squashes 1 (IF/ID only).
- Simultaneous branch_en and jump_en: branch wins; the jump is discarded (it sits on the wrong path).
- Alignment check applies to the selected target only (the winning redirect): selected target[1:0]!=0 → next state HALT, fetch_fault=1, pc unchanged, IF/ID bubbled, redirect not counted.
- FSM:
  - RUN: normal operation as above.
  - HALT: pc frozen, ifid_valid=0, ifid_instr=NOP_INSTR, kill_id=0, all inputs ignored, fetch_fault held 1.
  - Exit from HALT only via reset.
- redirect_count: +1 on each accepted redirect in RUN (branch or jump, aligned), saturates at all-ones.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately (async). The first fetch after release is from RESET_PC.

Decomposition:
- Shared package (core_pkg):
  - ADDR_W/INSTR_W defaults
  - NOP_INSTR encoding
  - fetch_state_t enum {RUN, HALT}
  - PC_INC constant (4)
- One natural sub-module: pc_next_sel.
  - Combinational priority mux plus alignment check.
  - Outputs: next_pc, redirect_accepted, misalign.
  - Reusable by the verification model.
- Registers, FSM and counter stay in fetch_stage.

Test Plan:
- Reset release, no stall/redirect, 4 cycles → imem_addr 0,4,8,12; ifid_valid=1 from cycle 1; ifid_pc_plus4 4,8,12 tracks.
- stall=1 for 3 cycles at pc=8 → pc stays 8, IF/ID holds the instruction from pc=4 for 3 cycles; resumes at pc=12 when released.
- branch_en=1, branch_target=0x40, while stall=1 → next pc=0x40, ifid_valid=0 next cycle, kill_id=1 that cycle, redirect_count=1.
- branch_en=1 (0x80) and jump_en=1 (0x100) same cycle → pc=0x80; count +1 only; kill_id=1.
- jump_target=0x102 → state HALT, fetch_fault=1, pc frozen, ifid_valid=0 permanently; subsequent valid branch ignored; reset clears the fault.
- Preload redirect_count=0xFFFE, issue 3 jumps → count 0xFFFF and holds; pc wrap case: pc=0xFFFFFFFC with no redirect → next pc=0.
